axi4_ar_sender: RTL and testbench

- Read-address stage of the RAB slave port.
- Accepts one AR transaction at a time from the slave side and issues a translation lookup. Then either forwards the AR with the translated address to the master side, or hands the transaction ID to the downstream R-channel sender as a drop request.
- Prefetch transactions are never forwarded. They are always dropped, with an OKAY response flag.

---
 rtl/axi_rab_pkg.sv | 21 ++
 rtl/axi4_ar_sender_if.sv | 28 ++
 rtl/axi4_ar_sender.sv | 137 +++++++++++++
 tb/tb_axi4_ar_sender.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rab_pkg.sv
// Shared definitions for the RAB AXI slave-port stages.
//   state_e      : AR sender FSM states
//   BURST_*      : AXI burst type encodings
//   RESP_*       : AXI response encodings used by the R-channel sender
package axi_rab_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    FORWARD = 2'd2,
    DROP    = 2'd3
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_ar_sender_if.sv
// AXI4 read-address channel bundle.
//   master modport : drives id/addr/len/size/burst/prot/user/valid, samples ready
//   slave  modport : samples the payload and valid, drives ready
interface axi4_ar_sender_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4
);
  logic [AXI_ID_WIDTH-1:0]   arid;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic [2:0]                arprot;
  logic [AXI_USER_WIDTH-1:0] aruser;
  logic                      arvalid;
  logic                      arready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arprot, aruser, arvalid,
    input  arready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arprot, aruser, arvalid,
    output arready
  );
endinterface

// File: rtl/axi4_ar_sender.sv
// Read-address stage of the RAB slave port.
// Takes one AR at a time, asks the TLB for a translation, then either
// forwards the AR with the translated address or hands its id to the
// R-channel sender as a drop request. Prefetches are always dropped.
//   axi4_aclk, axi4_arst : clock, synchronous active-high reset
//   s_axi4               : incoming AR channel (virtual address)
//   m_axi4               : outgoing AR channel (physical address)
//   lu_*                 : translation lookup request / response
//   trans_*              : drop request towards the R-channel sender
//   drop_cnt             : saturating count of issued drops
module axi4_ar_sender
  import axi_rab_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arst,
  axi4_ar_sender_if.slave           s_axi4,
  axi4_ar_sender_if.master          m_axi4,
  output logic                      lu_req,
  output logic [AXI_ADDR_WIDTH-1:0] lu_addr,
  output logic [AXI_ID_WIDTH-1:0]   lu_id,
  input  logic                      lu_resp_valid,
  input  logic                      lu_accept,
  input  logic                      lu_prefetch,
  input  logic [AXI_ADDR_WIDTH-1:0] lu_out_addr,
  output logic [AXI_ID_WIDTH-1:0]   trans_id,
  output logic                      trans_drop,
  output logic                      trans_prefetch,
  input  logic                      trans_ready,
  output logic [CNT_WIDTH-1:0]      drop_cnt
);

  state_e state_q, state_d;

  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic [2:0]                prot_q;
  logic [AXI_USER_WIDTH-1:0] user_q;
  logic                      trans_prefetch_q;
  logic [CNT_WIDTH-1:0]      cnt_q;

  logic arready_c, arvalid_c, lu_req_c, drop_c;

  // prefetch wins over accept: a prefetch is never forwarded
  logic fwd_ok;
  assign fwd_ok = lu_accept && !lu_prefetch;

  always_comb begin
    state_d   = state_q;
    arready_c = 1'b0;
    arvalid_c = 1'b0;
    lu_req_c  = 1'b0;
    drop_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        arready_c = 1'b1;
        if (s_axi4.arvalid) state_d = LOOKUP;
      end
      LOOKUP: begin
        lu_req_c = 1'b1;
        if (lu_resp_valid) state_d = fwd_ok ? FORWARD : DROP;
      end
      FORWARD: begin
        arvalid_c = 1'b1;
        if (m_axi4.arready) state_d = IDLE;
      end
      DROP: begin
        // one-cycle pulse: leaving DROP in the same cycle it is accepted
        drop_c = trans_ready;
        if (trans_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      state_q          <= IDLE;
      id_q             <= '0;
      addr_q           <= '0;
      len_q            <= '0;
      size_q           <= '0;
      burst_q          <= '0;
      prot_q           <= '0;
      user_q           <= '0;
      trans_prefetch_q <= 1'b0;
      cnt_q            <= '0;
    end else begin
      state_q <= state_d;
      if (arready_c && s_axi4.arvalid) begin
        id_q    <= s_axi4.arid;
        addr_q  <= s_axi4.araddr;
        len_q   <= s_axi4.arlen;
        size_q  <= s_axi4.arsize;
        burst_q <= s_axi4.arburst;
        prot_q  <= s_axi4.arprot;
        user_q  <= s_axi4.aruser;
      end
      if (lu_req_c && lu_resp_valid) begin
        // the captured virtual address is replaced only on a real hit
        if (fwd_ok) addr_q <= lu_out_addr;
        else        trans_prefetch_q <= lu_prefetch;
      end
      if (drop_c && (cnt_q != {CNT_WIDTH{1'b1}}))
        cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign s_axi4.arready  = arready_c;

  assign m_axi4.arvalid  = arvalid_c;
  assign m_axi4.arid     = id_q;
  assign m_axi4.araddr   = addr_q;
  assign m_axi4.arlen    = len_q;
  assign m_axi4.arsize   = size_q;
  assign m_axi4.arburst  = burst_q;
  assign m_axi4.arprot   = prot_q;
  assign m_axi4.aruser   = user_q;

  assign lu_req          = lu_req_c;
  assign lu_addr         = addr_q;
  assign lu_id           = id_q;

  assign trans_drop      = drop_c;
  assign trans_id        = id_q;
  assign trans_prefetch  = trans_prefetch_q;

  assign drop_cnt        = cnt_q;

endmodule

// File: tb/tb_axi4_ar_sender.sv
// Bench for axi4_ar_sender: a transaction-level model is updated on every
// rising edge from the bench's own stimulus; a compare process checks the DUT
// against it on every falling edge, and directed steps pin literal values.
module tb_axi4_ar_sender;
  localparam int AW = 32, IW = 4, UW = 4, CW = 2;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic clk = 1'b0, rst = 1'b1;
  logic lu_req, lu_resp_valid, lu_accept, lu_prefetch;
  logic [AW-1:0] lu_addr, lu_out_addr;
  logic [IW-1:0] lu_id, trans_id;
  logic trans_drop, trans_prefetch, trans_ready;
  logic [CW-1:0] drop_cnt;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  axi4_ar_sender_if #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) s_if ();
  axi4_ar_sender_if #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) m_if ();

  axi4_ar_sender #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW),
                   .CNT_WIDTH(CW)) dut (
    .axi4_aclk(clk), .axi4_arst(rst), .s_axi4(s_if), .m_axi4(m_if),
    .lu_req(lu_req), .lu_addr(lu_addr), .lu_id(lu_id),
    .lu_resp_valid(lu_resp_valid), .lu_accept(lu_accept),
    .lu_prefetch(lu_prefetch), .lu_out_addr(lu_out_addr),
    .trans_id(trans_id), .trans_drop(trans_drop),
    .trans_prefetch(trans_prefetch), .trans_ready(trans_ready),
    .drop_cnt(drop_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: one outstanding transaction ----------------
  bit            m_busy = 0, m_looked = 0, m_fwd = 0, m_pf = 0;
  logic [IW-1:0] m_id;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_len;
  logic [2:0]    m_size, m_prot;
  logic [1:0]    m_burst;
  logic [UW-1:0] m_user;
  int            m_drops = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_drops = 0;
    end else if (!m_busy) begin
      if (s_if.arvalid) begin
        m_busy = 1; m_looked = 0;
        m_id = s_if.arid; m_addr = s_if.araddr; m_len = s_if.arlen;
        m_size = s_if.arsize; m_burst = s_if.arburst; m_prot = s_if.arprot;
        m_user = s_if.aruser;
      end
    end else if (!m_looked) begin
      if (lu_resp_valid) begin
        m_looked = 1;
        m_fwd = lu_accept && !lu_prefetch;
        m_pf = lu_prefetch;
        if (m_fwd) m_addr = lu_out_addr;
      end
    end else if (m_fwd) begin
      if (m_if.arready) m_busy = 0;
    end else if (trans_ready) begin
      m_busy = 0;
      m_drops++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_drop_phase;
      logic [CW-1:0] exp_cnt;
      exp_drop_phase = m_busy && m_looked && !m_fwd;
      exp_cnt = (m_drops >= int'(CNT_MAX)) ? CNT_MAX : CW'(m_drops);
      chk("s_arready", 64'(s_if.arready), 64'(!m_busy));
      chk("lu_req", 64'(lu_req), 64'(m_busy && !m_looked));
      if (m_busy && !m_looked) begin
        chk("lu_addr", 64'(lu_addr), 64'(m_addr));
        chk("lu_id", 64'(lu_id), 64'(m_id));
      end
      chk("m_arvalid", 64'(m_if.arvalid), 64'(m_busy && m_looked && m_fwd));
      if (m_busy && m_looked && m_fwd) begin
        chk("m_araddr", 64'(m_if.araddr), 64'(m_addr));
        chk("m_arid", 64'(m_if.arid), 64'(m_id));
        chk("m_arlen", 64'(m_if.arlen), 64'(m_len));
        chk("m_arsize", 64'(m_if.arsize), 64'(m_size));
        chk("m_arburst", 64'(m_if.arburst), 64'(m_burst));
        chk("m_arprot", 64'(m_if.arprot), 64'(m_prot));
        chk("m_aruser", 64'(m_if.aruser), 64'(m_user));
      end
      chk("trans_drop", 64'(trans_drop), 64'(exp_drop_phase && trans_ready));
      if (exp_drop_phase) begin
        chk("trans_id", 64'(trans_id), 64'(m_id));
        chk("trans_prefetch", 64'(trans_prefetch), 64'(m_pf));
      end
      chk("drop_cnt", 64'(drop_cnt), 64'(exp_cnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len);
    s_if.arvalid = 1'b1; s_if.arid = id; s_if.araddr = addr; s_if.arlen = len;
    s_if.arsize = 3'd2; s_if.arburst = 2'b01; s_if.arprot = 3'd2; s_if.aruser = 4'hA;
    tick();
    s_if.arvalid = 1'b0;
  endtask

  task automatic lookup(input int dly, input logic acc, input logic pf,
                        input logic [AW-1:0] oaddr);
    repeat (dly) tick();
    lu_resp_valid = 1'b1; lu_accept = acc; lu_prefetch = pf; lu_out_addr = oaddr;
    tick();
    lu_resp_valid = 1'b0; lu_accept = 1'b0; lu_prefetch = 1'b0;
  endtask

  initial begin
    s_if.arvalid = 0; s_if.arid = 0; s_if.araddr = 0; s_if.arlen = 0;
    s_if.arsize = 0; s_if.arburst = 0; s_if.arprot = 0; s_if.aruser = 0;
    m_if.arready = 0; lu_resp_valid = 0; lu_accept = 0; lu_prefetch = 0;
    lu_out_addr = 0; trans_ready = 1;
    rst = 1;
    tick(); tick();
    // reset state
    chk("rst_s_arready", 64'(s_if.arready), 64'd1);
    chk("rst_lu_req", 64'(lu_req), 64'd0);
    chk("rst_m_arvalid", 64'(m_if.arvalid), 64'd0);
    chk("rst_trans_drop", 64'(trans_drop), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_m_araddr", 64'(m_if.araddr), 64'd0);
    rst = 0; chk_en = 1'b1;

    // 1: accepted translation, master backpressure for 4 cycles
    send_ar(4'd3, 32'h1000_0040, 8'd7);
    chk("t1_lu_addr", 64'(lu_addr), 64'h1000_0040);
    chk("t1_lu_id", 64'(lu_id), 64'd3);
    lookup(2, 1'b1, 1'b0, 32'h8000_0040);
    for (int i = 0; i < 4; i++) begin
      chk("t1_arvalid", 64'(m_if.arvalid), 64'd1);
      chk("t1_araddr", 64'(m_if.araddr), 64'h8000_0040);
      chk("t1_arid", 64'(m_if.arid), 64'd3);
      chk("t1_arlen", 64'(m_if.arlen), 64'd7);
      tick();
    end
    m_if.arready = 1'b1; tick(); m_if.arready = 1'b0;
    chk("t1_arvalid_off", 64'(m_if.arvalid), 64'd0);
    chk("t1_s_arready", 64'(s_if.arready), 64'd1);

    // 2: miss, drop immediately accepted; stray response in IDLE is ignored
    lu_resp_valid = 1'b1; lu_accept = 1'b1; tick();
    lu_resp_valid = 1'b0; lu_accept = 1'b0;
    chk("t2_idle_ignore", 64'(s_if.arready), 64'd1);
    send_ar(4'd5, 32'h2000_0000, 8'd0);
    lookup(0, 1'b0, 1'b0, 32'h0);
    chk("t2_drop", 64'(trans_drop), 64'd1);
    chk("t2_id", 64'(trans_id), 64'd5);
    chk("t2_pf", 64'(trans_prefetch), 64'd0);
    chk("t2_no_fwd", 64'(m_if.arvalid), 64'd0);
    tick();
    chk("t2_drop_off", 64'(trans_drop), 64'd0);
    chk("t2_cnt", 64'(drop_cnt), 64'd1);

    // 3: prefetch hit is dropped with OKAY flag
    send_ar(4'd9, 32'h3000_0000, 8'd3);
    lookup(1, 1'b1, 1'b1, 32'h9000_0000);
    chk("t3_drop", 64'(trans_drop), 64'd1);
    chk("t3_pf", 64'(trans_prefetch), 64'd1);
    chk("t3_no_fwd", 64'(m_if.arvalid), 64'd0);
    tick();
    chk("t3_cnt", 64'(drop_cnt), 64'd2);

    // 4: drop FIFO full for 3 cycles
    trans_ready = 1'b0;
    send_ar(4'd6, 32'h4000_0000, 8'd1);
    lookup(0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_drop", 64'(trans_drop), 64'd0);
      chk("t4_hold_id", 64'(trans_id), 64'd6);
      chk("t4_s_arready", 64'(s_if.arready), 64'd0);
      tick();
    end
    trans_ready = 1'b1; #1;
    chk("t4_drop", 64'(trans_drop), 64'd1);
    tick();
    chk("t4_cnt", 64'(drop_cnt), 64'd3);
    chk("t4_s_arready_back", 64'(s_if.arready), 64'd1);

    // 5: reset while forwarding under backpressure
    send_ar(4'd2, 32'h5000_0000, 8'd0);
    lookup(0, 1'b1, 1'b0, 32'hA000_0000);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_arvalid", 64'(m_if.arvalid), 64'd0);
    chk("t5_s_arready", 64'(s_if.arready), 64'd1);
    chk("t5_cnt", 64'(drop_cnt), 64'd0);
    send_ar(4'd1, 32'h6000_0010, 8'd2);
    lookup(0, 1'b1, 1'b0, 32'hB000_0010);
    chk("t5_new_araddr", 64'(m_if.araddr), 64'hB000_0010);
    chk("t5_new_arid", 64'(m_if.arid), 64'd1);
    m_if.arready = 1'b1; tick(); m_if.arready = 1'b0;

    // 6: counter saturation, expected 1,2,3,3,3
    begin
      logic [CW-1:0] seq [5];
      seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
        send_ar(IW'(i + 8), 32'h7000_0000, 8'd0);
        lookup(0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("t6_cnt", 64'(drop_cnt), 64'(seq[i]));
      end
    end

    tick(); tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
